// File: rtl/chunk_add_seq.sv
// chunk_add_seq: multi-cycle wide adder that walks one CHUNK-bit ripple slice
// over the operands, least-significant chunk first, with valid/ready on both
// the operand side and the result side.
module chunk_add_seq #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK:0]   w_chunkSum;
  logic             w_lastChunk;
  logic             w_accept;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_lastChunk = (r_idx == IDXW'(N - 1));
  assign w_chunkSum  = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
  assign sum         = r_sum;
  assign cout        = r_cout;

  // Select the operand chunks addressed by the index (constant-index mux keeps selects in range).
  always_comb begin
    w_aChunk = '0;
    w_bChunk = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_aChunk = r_a[i*CHUNK +: CHUNK];
        w_bChunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastChunk) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then add one chunk per cycle and ripple the carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_carry <= w_chunkSum[CHUNK];
      for (int i = 0; i < N; i++) begin
        if (r_idx == IDXW'(i)) begin
          r_sum[i*CHUNK +: CHUNK] <= w_chunkSum[CHUNK-1:0];
        end
      end
      if (w_lastChunk) begin
        r_cout <= w_chunkSum[CHUNK];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chunk_add_seq.sv
// tb_chunk_add_seq: directed and random operations on a 12/3 instance and a
// 6/3 instance, checked against plain integer addition.
module tb_chunk_add_seq;

  localparam int W  = 12;
  localparam int C  = 3;
  localparam int N  = W / C;
  localparam int W6 = 6;
  localparam int N6 = W6 / C;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;

  logic          in_valid6;
  logic          in_ready6;
  logic [W6-1:0] a6;
  logic [W6-1:0] b6;
  logic          cin6;
  logic          out_valid6;
  logic          out_ready6;
  logic [W6-1:0] sum6;
  logic          cout6;
  logic          busy6;

  int nCompared;
  int nMismatched;
  int cyc;

  chunk_add_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  chunk_add_seq #(.WIDTH(W6), .CHUNK(C)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
    .a(a6), .b(b6), .cin(cin6), .out_valid(out_valid6), .out_ready(out_ready6),
    .sum(sum6), .cout(cout6), .busy(busy6)
  );

  // Free-running clock and a cycle counter used to measure accept spacing.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case a wait goes wrong.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation on the 12-bit instance; called #1 after an edge with the DUT idle.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                               input int hold, input bit poke);
    logic [W:0]   expFull;
    logic [W-1:0] heldSum;
    logic         heldCout;
    int           cnt;
    expFull = (W+1)'(ta) + (W+1)'(tb) + (W+1)'(tcin);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 3*N) begin
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("latency", 32'(cnt), 32'(N));
    checkOutput("sum", 32'(sum), 32'(expFull[W-1:0]));
    checkOutput("cout", 32'(cout), 32'(expFull[W]));
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);
    heldSum  = expFull[W-1:0];
    heldCout = expFull[W];
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        in_valid = 1'b1; a = 12'hFFF; b = W'($urandom);
      end
      if (poke && i == 2) in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_sum", 32'(sum), 32'(heldSum));
      checkOutput("hold_cout", 32'(cout), 32'(heldCout));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("after_hs_valid", 32'(out_valid), 32'd0);
    checkOutput("after_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0]  bbA [3];
    logic [W-1:0]  bbB [3];
    logic          bbC [3];
    int            acc [3];
    logic [W:0]    expB;
    logic [W6:0]   exp6;
    logic [W6-1:0] ta6;
    logic [W6-1:0] tb6;
    logic          tc6;
    int            cnt;

    nCompared = 0; nMismatched = 0; cyc = 0;
    in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
    in_valid6 = 0; a6 = '0; b6 = '0; cin6 = 0; out_ready6 = 0;

    // Reset values
    rst = 1'b1;
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full carry ripple, plain handshake, backpressure with ignored poke
    applyStimulus(12'hFFF, 12'h001, 1'b0, 0, 1'b0);
    applyStimulus(12'h5A5, 12'h0F0, 1'b1, 0, 1'b0);
    applyStimulus(12'h123, 12'h456, 1'b0, 5, 1'b1);
    applyStimulus(12'h00A, 12'h014, 1'b0, 0, 1'b0);

    // Reset two cycles into RUN
    a = 12'hFFF; b = 12'hFFF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_sum", 32'(sum), 32'd0);
    checkOutput("midrst_cout", 32'(cout), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(12'h001, 12'h002, 1'b0, 0, 1'b0);

    // Random operations
    for (int k = 0; k < 16; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    // Back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 3; k++) begin
      bbA[k] = W'($urandom); bbB[k] = W'($urandom); bbC[k] = 1'($urandom);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = bbA[k]; b = bbB[k]; cin = bbC[k];
      expB = (W+1)'(bbA[k]) + (W+1)'(bbB[k]) + (W+1)'(bbC[k]);
      cnt = 0;
      while (!in_ready && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      checkOutput("b2b_ready", 32'(in_ready), 32'd1);
      acc[k] = cyc;
      if (k > 0) checkOutput("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'(N + 2));
      @(posedge clk); #1;
      if (k == 2) in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      checkOutput("b2b_latency", 32'(cnt), 32'(N));
      checkOutput("b2b_sum", 32'(sum), 32'(expB[W-1:0]));
      checkOutput("b2b_cout", 32'(cout), 32'(expB[W]));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("b2b_end_idle", 32'(in_ready), 32'd1);

    // Narrow instance: two chunks
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        ta6 = 6'h3F; tb6 = 6'h3F; tc6 = 1'b1;
      end else begin
        ta6 = W6'($urandom); tb6 = W6'($urandom); tc6 = 1'($urandom);
      end
      exp6 = (W6+1)'(ta6) + (W6+1)'(tb6) + (W6+1)'(tc6);
      checkOutput("w6_in_ready", 32'(in_ready6), 32'd1);
      a6 = ta6; b6 = tb6; cin6 = tc6; in_valid6 = 1'b1;
      @(posedge clk); #1;
      in_valid6 = 1'b0;
      cnt = 0;
      while (!out_valid6 && cnt < 10) begin
        checkOutput("w6_busy", 32'(busy6), 32'd1);
        @(posedge clk); #1;
        cnt++;
      end
      checkOutput("w6_latency", 32'(cnt), 32'(N6));
      checkOutput("w6_sum", 32'(sum6), 32'(exp6[W6-1:0]));
      checkOutput("w6_cout", 32'(cout6), 32'(exp6[W6]));
      out_ready6 = 1'b1;
      @(posedge clk); #1;
      out_ready6 = 1'b0;
      checkOutput("w6_after_hs", 32'(out_valid6), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/chunk_add_seq.md
Name: chunk_add_seq

Overview:
Multi-cycle adder controller. It sequences one CHUNK-bit ripple-carry adder slice over the WIDTH/CHUNK chunks of two WIDTH-bit operands, least-significant chunk first. A carry register links consecutive chunks. Operands enter and results leave through valid/ready handshakes, so the block can sit between a requester and a consumer wherever a wide add is needed without a wide combinational carry chain.

Parameters:
WIDTH, 12, operand and result width in bits; must be an integer multiple of CHUNK.
CHUNK, 3, width of the adder slice in bits; the block processes one chunk per clock.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operands a, b and cin are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in to chunk 0.
out_valid  output  1  sum and cout hold a completed result; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result bits WIDTH-1:0 of a+b+cin.
cout  output  1  carry out of the top chunk.
busy  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: state=IDLE, chunk index=0, carry register=0, operand registers=0, sum=0, cout=0. Outputs after reset: out_valid=0, busy=0, in_ready=1.
- A reset asserted in RUN or DONE aborts the operation immediately and returns to the reset state. The in-flight result is discarded and never presented.
- State machine: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid & in_ready. At that edge the block latches a, b and cin (cin goes into the carry register) and clears the index to 0.
- RUN: each edge computes {c, s} = a[idx] + b[idx] + carry on the CHUNK-bit chunk idx. It writes s into sum bits [idx*CHUNK +: CHUNK], writes c into the carry register, and increments idx.
- On the edge that processes chunk N-1 (N = WIDTH/CHUNK), the block goes to DONE and cout takes that chunk's carry. The index wraps to 0.
- Latency: out_valid rises exactly N cycles after the accept edge. Throughput is one operation per N+2 cycles minimum.
- DONE: out_valid=1. sum and cout are held stable until the handshake completes. DONE -> IDLE on out_ready.
- in_ready is 0 in DONE, so a new operation cannot be accepted on the same edge as the result handshake.
- in_valid during RUN or DONE is ignored and the operands are not sampled. Input changes after the accept edge have no effect.
- Outside DONE, sum and cout show partial or stale values; consumers qualify them with out_valid.
- Arithmetic: unsigned modulo 2^WIDTH. The full result is {cout, sum} = a + b + cin.
- Degenerate case WIDTH=CHUNK (N=1): one RUN cycle, and the block still uses all three states.

Test Plan:
- WIDTH=12, CHUNK=3: a=0xFFF, b=0x001, cin=0 -> out_valid 4 cycles after accept; sum=0x000, cout=1. The carry must propagate through all four chunks.
- a=0x5A5, b=0x0F0, cin=1 with out_ready held high -> sum=0x696, cout=0. The block returns to IDLE one cycle after out_valid, and in_ready is low during RUN and DONE.
- Backpressure: a=0x123, b=0x456, cin=0, with out_ready low for 5 cycles after out_valid -> sum=0x579 and cout=0 held stable. A pulse on in_valid with a=0xFFF during DONE is ignored, and the next result is from the next accepted operands.
- Reset mid-RUN: accept a=0xFFF, b=0xFFF, assert rst asynchronously two cycles later -> outputs go to their reset values immediately and out_valid never asserts. A following operation a=0x001, b=0x002, cin=0 yields sum=0x003, cout=0.
- Back-to-back: in_valid held high with three operand sets -> accepts are spaced N+2=6 cycles apart, and each result matches its own operands.
- Parameter variant WIDTH=6, CHUNK=3: a=0x3F, b=0x3F, cin=1 -> sum=0x3F, cout=1, 2 cycles after accept.
